// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one transaction in flight.
// Optional fetch-fairness streak limit is compiled in with `define MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_valid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  resp_err,
    output logic                  arb_busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(MEM_TIMEOUT - 1);

    if (MAX_D_STREAK < 1 || MAX_D_STREAK > 15 || MEM_TIMEOUT < 1 || MEM_TIMEOUT > 65535) begin : g_bad_param
        $error("mem_port_arbiter: MAX_D_STREAK or MEM_TIMEOUT out of range");
    end

    logic [1:0]    state;
    logic          owner_d;
    logic [TW-1:0] timeout_cnt;
    logic          any_req;
    logic          pick_d;

    assign any_req = if_req | d_req;

`ifdef MEM_ARB_FAIRNESS_EN
    logic [3:0] d_streak;

    // Fetch overrides data only once data has starved it for MAX_D_STREAK grants in a row.
    always_comb begin
        pick_d = d_req && !(if_req && (d_streak == 4'(MAX_D_STREAK)));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            d_streak <= '0;
        end else if (state == IDLE && any_req) begin
            if (pick_d && if_req) begin
                d_streak <= (d_streak == 4'hF) ? 4'hF : d_streak + 4'd1;
            end else begin
                d_streak <= '0;
            end
        end
    end
`else
    always_comb begin
        pick_d = d_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner_d     <= 1'b0;
            timeout_cnt <= '0;
            if_gnt      <= 1'b0;
            if_valid    <= 1'b0;
            if_rdata    <= '0;
            d_gnt       <= 1'b0;
            d_valid     <= 1'b0;
            d_rdata     <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            resp_err    <= 1'b0;
            arb_busy    <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere so every flop in this block sees pre-edge values;
            // pulse outputs default low here and are raised only on the cycle they apply.
            if_gnt   <= 1'b0;
            d_gnt    <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_req) begin
                        state       <= ISSUE;
                        arb_busy    <= 1'b1;
                        mem_req     <= 1'b1;
                        timeout_cnt <= '0;
                        resp_err    <= 1'b0;
                        owner_d     <= pick_d;
                        if (pick_d) begin
                            d_gnt     <= 1'b1;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            if_gnt    <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                        end
                    end
                end

                ISSUE: begin
                    if (mem_ready) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        if (owner_d) begin
                            d_valid <= 1'b1;
                            d_rdata <= mem_we ? '0 : mem_rdata;
                        end else begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                        // Abort on the cycle the count reaches MEM_TIMEOUT; it never wraps.
                        if (timeout_cnt == TIMEOUT_LAST) begin
                            state    <= RESP;
                            mem_req  <= 1'b0;
                            resp_err <= 1'b1;
                            if (owner_d) begin
                                d_valid <= 1'b1;
                                d_rdata <= '0;
                            end else begin
                                if_valid <= 1'b1;
                                if_rdata <= '0;
                            end
                        end
                    end
                end

                RESP: begin
                    state       <= IDLE;
                    arb_busy    <= 1'b0;
                    resp_err    <= 1'b0;
                    timeout_cnt <= '0;
                end

                default: begin
                    state    <= IDLE;
                    arb_busy <= 1'b0;
                    mem_req  <= 1'b0;
                    resp_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_TIMEOUT=8, MAX_D_STREAK=4).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        resp_err;
    logic        arb_busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MAX_D_STREAK(4),
        .MEM_TIMEOUT (8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_valid (if_valid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_valid  (d_valid),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .resp_err (resp_err),
        .arb_busy (arb_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic exp_fetch;

        reset_n   = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;

        // Reset state
        step();
        step();
        check("rst_if_gnt", if_gnt, 0);
        check("rst_d_gnt", d_gnt, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_d_valid", d_valid, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_arb_busy", arb_busy, 0);
        reset_n = 1'b1;
        step();
        check("idle_no_req", arb_busy, 0);

        // Single fetch, memory ready in first ISSUE cycle
        if_req  = 1'b1;
        if_addr = 32'h100;
        step();
        check("f_if_gnt", if_gnt, 1);
        check("f_d_gnt", d_gnt, 0);
        check("f_mem_req", mem_req, 1);
        check("f_mem_we", mem_we, 0);
        check("f_mem_addr", mem_addr, 32'h100);
        check("f_busy", arb_busy, 1);
        if_req    = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h0050_0093;
        step();
        mem_ready = 1'b0;
        check("f_if_valid", if_valid, 1);
        check("f_if_rdata", if_rdata, 32'h0050_0093);
        check("f_resp_err", resp_err, 0);
        check("f_if_gnt_pulse", if_gnt, 0);
        check("f_mem_req_drop", mem_req, 0);
        step();
        check("f_valid_pulse", if_valid, 0);
        check("f_idle", arb_busy, 0);

        // Load
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h3000;
        step();
        check("ld_d_gnt", d_gnt, 1);
        check("ld_mem_we", mem_we, 0);
        check("ld_mem_addr", mem_addr, 32'h3000);
        d_req     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        step();
        mem_ready = 1'b0;
        check("ld_d_valid", d_valid, 1);
        check("ld_d_rdata", d_rdata, 32'hCAFE_F00D);
        check("ld_if_valid", if_valid, 0);
        check("ld_if_rdata_held", if_rdata, 32'h0050_0093);
        step();

        // Store with three wait cycles
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h2000;
        d_wdata = 32'hDEAD_BEEF;
        step();
        check("st_d_gnt", d_gnt, 1);
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            check("st_mem_req", mem_req, 1);
            check("st_mem_we", mem_we, 1);
            check("st_mem_addr", mem_addr, 32'h2000);
            check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("st_no_valid", d_valid, 0);
            if (i == 3) begin
                mem_ready = 1'b1;
                mem_rdata = 32'h1234_5678;
            end
            if (i < 3) step();
        end
        step();
        mem_ready = 1'b0;
        check("st_d_valid", d_valid, 1);
        check("st_d_rdata_zero", d_rdata, 0);
        check("st_resp_err", resp_err, 0);
        check("st_d_gnt_pulse", d_gnt, 0);
        step();
        check("st_idle", arb_busy, 0);

        // Contention: data wins, fetch waits through RESP and IDLE
        if_req  = 1'b1;
        if_addr = 32'h104;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h4000;
        step();
        check("ct_d_gnt", d_gnt, 1);
        check("ct_if_gnt", if_gnt, 0);
        check("ct_mem_addr", mem_addr, 32'h4000);
        d_req     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h11;
        step();
        mem_ready = 1'b0;
        check("ct_d_valid", d_valid, 1);
        check("ct_if_gnt_resp", if_gnt, 0);
        step();
        check("ct_if_gnt_idle", if_gnt, 0);
        check("ct_idle", arb_busy, 0);
        step();
        check("ct_if_gnt_late", if_gnt, 1);
        check("ct_mem_addr2", mem_addr, 32'h104);
        if_req    = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h22;
        step();
        mem_ready = 1'b0;
        check("ct_if_valid", if_valid, 1);
        check("ct_if_rdata", if_rdata, 32'h22);
        check("ct_d_rdata_held", d_rdata, 32'h11);
        step();

        // Both requests held across five arbitrations
        if_req  = 1'b1;
        if_addr = 32'h108;
        d_req   = 1'b1;
        d_addr  = 32'h4004;
        for (int k = 1; k <= 5; k++) begin
`ifdef MEM_ARB_FAIRNESS_EN
            exp_fetch = (k == 5);
`else
            exp_fetch = 1'b0;
`endif
            step();
            check("sk_if_gnt", if_gnt, exp_fetch);
            check("sk_d_gnt", d_gnt, !exp_fetch);
            check("sk_mem_addr", mem_addr, exp_fetch ? 32'h108 : 32'h4004);
            mem_ready = 1'b1;
            mem_rdata = 32'h100 + k;
            step();
            mem_ready = 1'b0;
            check("sk_valid", exp_fetch ? if_valid : d_valid, 1);
            step();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        step();

        // Timeout on a fetch: eight ISSUE cycles then error response
        if_req  = 1'b1;
        if_addr = 32'h200;
        step();
        check("to_if_gnt", if_gnt, 1);
        if_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("to_mem_req", mem_req, 1);
            check("to_no_valid", if_valid, 0);
            if (i < 7) step();
        end
        step();
        check("to_if_valid", if_valid, 1);
        check("to_resp_err", resp_err, 1);
        check("to_if_rdata", if_rdata, 0);
        check("to_mem_req_drop", mem_req, 0);
        step();
        check("to_err_clear", resp_err, 0);
        check("to_valid_pulse", if_valid, 0);
        check("to_idle", arb_busy, 0);

        // Reset during ISSUE drops the transaction
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h5000;
        d_wdata = 32'hA5A5_A5A5;
        step();
        check("rm_d_gnt", d_gnt, 1);
        d_req = 1'b0;
        d_we  = 1'b0;
        step();
        check("rm_mem_req_pre", mem_req, 1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("rm_mem_req", mem_req, 0);
        check("rm_d_valid", d_valid, 0);
        check("rm_arb_busy", arb_busy, 0);
        check("rm_mem_we", mem_we, 0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check("rm_no_valid", d_valid, 0);
        check("rm_still_idle", arb_busy, 0);
        if_req  = 1'b1;
        if_addr = 32'h300;
        step();
        check("rm_if_gnt", if_gnt, 1);
        check("rm_mem_addr", mem_addr, 32'h300);
        if_req    = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h33;
        step();
        mem_ready = 1'b0;
        check("rm_if_valid", if_valid, 1);
        check("rm_if_rdata", if_rdata, 32'h33);
        check("rm_resp_err", resp_err, 0);
        step();
        check("rm_idle", arb_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch requester and the data (load/store) requester of the RISC-V core.
- Sits between the fetch/PC stage, the load/store path (driven by mem_write / wb_sel decode), and the memory macro.
- Holds one transaction in flight: arbitrate, issue with ready handshake, return response; bounded wait with timeout error.
- Outputs are registered.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- MAX_D_STREAK, 4, consecutive data grants allowed while fetch waits (fairness feature only); range 1..15.
- MEM_TIMEOUT, 255, cycles in ISSUE without mem_ready before aborting; range 1..65535.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset_n  input  1  synchronous active-low reset.
- if_req  input  1  fetch request; held until if_gnt.
- if_addr  input  ADDR_WIDTH  fetch address.
- if_gnt  output  1  one-cycle pulse: fetch request accepted.
- if_valid  output  1  one-cycle pulse: fetch response valid.
- if_rdata  output  DATA_WIDTH  fetched instruction; held until next if_valid.
- d_req  input  1  data request; held until d_gnt.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_WIDTH  data address.
- d_wdata  input  DATA_WIDTH  store data.
- d_gnt  output  1  one-cycle pulse: data request accepted.
- d_valid  output  1  one-cycle pulse: data response (load data or store ack).
- d_rdata  output  DATA_WIDTH  load data; 0 for stores.
- mem_req  output  1  memory request; stable until mem_ready.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_ready  input  1  memory completes access this cycle; mem_rdata valid.
- mem_rdata  input  DATA_WIDTH  memory read data.
- resp_err  output  1  coincides with if_valid/d_valid when transaction timed out.
- arb_busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: on a clk edge with reset_n=0 the state goes to IDLE. All outputs go to 0: gnt, valid, rdata, mem_* and resp_err. The owner, timeout counter and streak counter clear.
- Reset mid-transaction: the transaction is dropped with no valid pulse. mem_req is low from the next cycle.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Requests are sampled. Winner is d_req over if_req (strict data priority).
  - At the edge: latch owner and mem_we/addr/wdata (fetch forces mem_we=0). Go to ISSUE.
  - In the first ISSUE cycle, winner's gnt=1 and mem_req=1.
  - With no requests, stay in IDLE.
- ISSUE:
  - mem_req and fields stay stable.
  - If mem_ready=1: register mem_rdata into the owner's rdata (d_rdata=0 if store) and go to RESP.
  - Else increment the timeout counter. When it reaches MEM_TIMEOUT, go to RESP with resp_err set, rdata=0 and mem_req dropped.
- RESP: owner's valid=1 for one cycle, resp_err as set. Then go to IDLE and clear the counter.
- Latency: request at cycle N → gnt at N+1 → valid at N+2 minimum (mem_ready at N+1). Peak throughput is one transaction per 3 cycles.
- Requests raised or changed while not in IDLE are ignored until IDLE. A requester may keep req high after gnt to queue its next access.
- Simultaneous if_req and d_req: data wins. Fetch stays pending and is not granted.
- Timeout counter width is $clog2(MEM_TIMEOUT+1); no wrap.
- Streak counter width is 4 bits and saturates.

Optional Feature:
- Macro: MEM_ARB_FAIRNESS_EN.
- Defined: a streak counter increments on each data grant made while if_req=1. It clears on any fetch grant, and on a data grant with if_req=0. When streak==MAX_D_STREAK and both requests are present, fetch wins that arbitration.
- Undefined: strict data priority; the counter is not built.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100; mem_ready at first ISSUE cycle, mem_rdata=0x00500093 → if_gnt cycle 1, if_valid cycle 2 with if_rdata=0x00500093, resp_err=0.
- Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF; mem_ready after 3 wait cycles → mem_we=1 with stable fields for 4 cycles, then d_valid=1 with d_rdata=0.
- Contention: if_req and d_req both high from cycle 0 → d_gnt first, if_gnt only after d_valid + IDLE cycle. With MEM_ARB_FAIRNESS_EN and MAX_D_STREAK=4, d_req held high → fetch granted on the 5th arbitration.
- Timeout: MEM_TIMEOUT=8, mem_ready held 0 → mem_req high 8 cycles, then valid with resp_err=1, rdata=0, state IDLE.
- Reset mid-op: reset_n=0 for one edge during ISSUE → mem_req=0 next cycle, no valid pulse, arb_busy=0; new if_req afterwards serviced normally.
